// File: rtl/img_data_depkt_if.sv
// Bundles the FWFT FIFO read side and the reconstructed video timing outputs.
// The depacketizer holds the master modport; the FIFO/sink side holds the slave.
interface img_data_depkt_if;
    logic        fifo_empty;
    logic [31:0] fifo_dout;
    logic        fifo_rd_en;
    logic        post_frame_vsync;
    logic        post_frame_hsync;
    logic        post_frame_de;
    logic [15:0] post_rgb;
    logic        frame_done;
    logic [15:0] underflow_cnt;

    modport master (
        input  fifo_empty, fifo_dout,
        output fifo_rd_en, post_frame_vsync, post_frame_hsync, post_frame_de,
               post_rgb, frame_done, underflow_cnt
    );

    modport slave (
        output fifo_empty, fifo_dout,
        input  fifo_rd_en, post_frame_vsync, post_frame_hsync, post_frame_de,
               post_rgb, frame_done, underflow_cnt
    );
endinterface

// File: rtl/img_data_depkt.sv
// Rebuilds an RGB565 vsync/hsync/de stream from 2-pixel words read out of a FWFT FIFO.
// Pixel latency 1 cycle; an empty FIFO mid-line stalls the line with de low and hsync held.
module img_data_depkt #(
    parameter int          H_DISP     = 640,
    parameter int          V_DISP     = 480,
    parameter int          H_BLANK    = 16,
    parameter int          VS_CYC     = 64,
    parameter logic [31:0] FRAME_HEAD = 32'hF05A_A50F
) (
    input  logic             cam_pclk,
    input  logic             rst_n,
    input  logic             enable,
    img_data_depkt_if.master bus
);
    localparam int PW   = (H_DISP > 1) ? $clog2(H_DISP) : 1;
    localparam int LW   = (V_DISP > 1) ? $clog2(V_DISP) : 1;
    localparam int CMAX = (VS_CYC > H_BLANK) ? VS_CYC : H_BLANK;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [PW-1:0] PIX_LAST  = PW'(H_DISP - 1);
    localparam logic [LW-1:0] LINE_LAST = LW'(V_DISP - 1);
    localparam logic [CW-1:0] VS_LAST   = CW'(VS_CYC - 1);
    localparam logic [CW-1:0] HB_LAST   = CW'(H_BLANK - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HUNT,
        S_VSYNC,
        S_LINE,
        S_HBLANK,
        S_DONE
    } state_t;

    state_t          state_q;
    logic            half_q;
    logic [PW-1:0]   pix_q;
    logic [LW-1:0]   line_q;
    logic [CW-1:0]   cnt_q;
    logic            vsync_q;
    logic            hsync_q;
    logic            de_q;
    logic [15:0]     rgb_q;
    logic            done_q;
    logic [15:0]     ufl_q;

    logic            emit;
    logic [15:0]     pix_d;

    assign emit  = (state_q == S_LINE) && !bus.fifo_empty;
    assign pix_d = half_q ? bus.fifo_dout[15:0] : bus.fifo_dout[31:16];

    // A word leaves the FIFO together with its lower pixel, so the upper one is read from the head in place.
    assign bus.fifo_rd_en = !bus.fifo_empty &&
                            ((state_q == S_HUNT) || ((state_q == S_LINE) && half_q));

    always_ff @(posedge cam_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            half_q  <= 1'b0;
            pix_q   <= '0;
            line_q  <= '0;
            cnt_q   <= '0;
            vsync_q <= 1'b0;
            hsync_q <= 1'b0;
            de_q    <= 1'b0;
            rgb_q   <= '0;
            done_q  <= 1'b0;
            ufl_q   <= '0;
        end else begin
            // Timing outputs are the registered image of the current state, which keeps them aligned with de.
            vsync_q <= (state_q == S_VSYNC);
            hsync_q <= (state_q == S_LINE);
            de_q    <= emit;
            rgb_q   <= emit ? pix_d : 16'h0000;
            done_q  <= (state_q == S_DONE);

            case (state_q)
                S_IDLE: begin
                    if (enable) state_q <= S_HUNT;
                end
                S_HUNT: begin
                    if (!bus.fifo_empty && (bus.fifo_dout == FRAME_HEAD)) begin
                        state_q <= S_VSYNC;
                        cnt_q   <= '0;
                        pix_q   <= '0;
                        line_q  <= '0;
                        half_q  <= 1'b0;
                    end
                end
                S_VSYNC: begin
                    if (cnt_q == VS_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_LINE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_LINE: begin
                    if (emit) begin
                        half_q <= ~half_q;
                        if (pix_q == PIX_LAST) begin
                            pix_q <= '0;
                            if (line_q == LINE_LAST) begin
                                line_q  <= '0;
                                state_q <= S_DONE;
                            end else begin
                                line_q  <= line_q + LW'(1);
                                cnt_q   <= '0;
                                state_q <= S_HBLANK;
                            end
                        end else begin
                            pix_q <= pix_q + PW'(1);
                        end
                    end else if (ufl_q != 16'hFFFF) begin
                        ufl_q <= ufl_q + 16'd1;
                    end
                end
                S_HBLANK: begin
                    if (cnt_q == HB_LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_LINE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                    state_q <= enable ? S_HUNT : S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.post_frame_vsync = vsync_q;
    assign bus.post_frame_hsync = hsync_q;
    assign bus.post_frame_de    = de_q;
    assign bus.post_rgb         = rgb_q;
    assign bus.frame_done       = done_q;
    assign bus.underflow_cnt    = ufl_q;
endmodule
